// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control-word bit positions,
// write-destination encodings and the destination resolution helper.
package id_ex_stage_pkg;

    localparam int CTRL_LOAD     = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REGWE    = 3;
    localparam int CTRL_WDST_LO  = 18;
    localparam int CTRL_WDST_HI  = 19;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        WDST_NONE = 2'b00,
        WDST_RT   = 2'b01,
        WDST_R31  = 2'b10,
        WDST_RD   = 2'b11
    } wdst_e;

    // Picks the architectural write register from the WriteDestination field.
    function automatic logic [4:0] resolve_dest(input logic [1:0] wdst,
                                                input logic [4:0] rt,
                                                input logic [4:0] rd);
        logic [4:0] dest;
        case (wdst)
            WDST_RT:  dest = rt;
            WDST_R31: dest = REG_RA;
            WDST_RD:  dest = rd;
            default:  dest = REG_ZERO;
        endcase
        return dest;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detector; a flush overrides the stall so the
// redirected fetch is never held.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       i_exValid,
    input  logic       i_exLoad,
    input  logic [4:0] i_exDest,
    input  logic       i_idValid,
    input  logic [4:0] i_idRs,
    input  logic [4:0] i_idRt,
    input  logic       i_flush,
    output logic       o_hazard,
    output logic       o_cmuxSel,
    output logic       o_pcWriteEn,
    output logic       o_ifidWriteEn
);

    logic w_rsMatch;
    logic w_rtMatch;
    logic w_stall;

    assign w_rsMatch = (i_exDest == i_idRs) && (i_idRs != REG_ZERO);
    assign w_rtMatch = (i_exDest == i_idRt) && (i_idRt != REG_ZERO);

    assign o_hazard = i_exValid && i_exLoad && (i_exDest != REG_ZERO) &&
                      (w_rsMatch || w_rtMatch) && i_idValid;

    assign w_stall       = o_hazard && !i_flush;
    assign o_cmuxSel     = !w_stall;
    assign o_pcWriteEn   = !w_stall;
    assign o_ifidWriteEn = !w_stall;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves the destination register, captures the
// decoded instruction for EX and inserts one-cycle bubbles on load-use hazards.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [15:0]       id_imm16,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              flush,
    output logic              cmux_sel,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [15:0]       ex_imm16,
    output logic [4:0]        ex_dest,
    output logic [15:0]       stall_count
);

    logic              r_exValid;
    logic [CTRL_W-1:0] r_exCtrl;
    logic [DATA_W-1:0] r_exPc;
    logic [DATA_W-1:0] r_exRsVal;
    logic [DATA_W-1:0] r_exRtVal;
    logic [15:0]       r_exImm16;
    logic [4:0]        r_exDest;
    logic [15:0]       r_stallCount;

    logic [4:0] w_idDest;
    logic       w_hazard;
    logic       w_bubble;

    assign w_idDest = resolve_dest(id_ctrl[CTRL_WDST_HI:CTRL_WDST_LO], id_rt, id_rd);

    hazard_detect u_hazard_detect (
        .i_exValid     (r_exValid),
        .i_exLoad      (r_exCtrl[CTRL_LOAD]),
        .i_exDest      (r_exDest),
        .i_idValid     (id_valid),
        .i_idRs        (id_rs),
        .i_idRt        (id_rt),
        .i_flush       (flush),
        .o_hazard      (w_hazard),
        .o_cmuxSel     (cmux_sel),
        .o_pcWriteEn   (pc_write_en),
        .o_ifidWriteEn (ifid_write_en)
    );

    // Flush, hazard and an empty ID slot all collapse to the same all-zero bubble.
    assign w_bubble = flush || w_hazard || !id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exValid    <= 1'b0;
            r_exCtrl     <= '0;
            r_exPc       <= '0;
            r_exRsVal    <= '0;
            r_exRtVal    <= '0;
            r_exImm16    <= '0;
            r_exDest     <= '0;
            r_stallCount <= '0;
        end else begin
            if (w_bubble) begin
                r_exValid <= 1'b0;
                r_exCtrl  <= '0;
                r_exPc    <= '0;
                r_exRsVal <= '0;
                r_exRtVal <= '0;
                r_exImm16 <= '0;
                r_exDest  <= '0;
            end else begin
                r_exValid <= 1'b1;
                r_exCtrl  <= id_ctrl;
                r_exPc    <= id_pc;
                r_exRsVal <= id_rs_val;
                r_exRtVal <= id_rt_val;
                r_exImm16 <= id_imm16;
                r_exDest  <= w_idDest;
            end
            // Only stalls that actually hold the front end are counted.
            if (w_hazard && !flush && (r_stallCount != 16'hFFFF)) begin
                r_stallCount <= r_stallCount + 16'd1;
            end
        end
    end

    assign ex_valid    = r_exValid;
    assign ex_ctrl     = r_exCtrl;
    assign ex_pc       = r_exPc;
    assign ex_rs_val   = r_exRsVal;
    assign ex_rt_val   = r_exRtVal;
    assign ex_imm16    = r_exImm16;
    assign ex_dest     = r_exDest;
    assign stall_count = r_stallCount;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: capture, destination resolution,
// load-use stalls, flush priority, counter saturation and async reset.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [23:0] id_ctrl;
    logic [31:0] id_pc;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [15:0] id_imm16;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        flush;
    logic        cmux_sel;
    logic        pc_write_en;
    logic        ifid_write_en;
    logic        ex_valid;
    logic [23:0] ex_ctrl;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic [15:0] ex_imm16;
    logic [4:0]  ex_dest;
    logic [15:0] stall_count;

    int vectors;
    int miscompares;
    logic [15:0] expStall;

    id_ex_stage #(.DATA_W(32), .CTRL_W(24)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_ctrl       (id_ctrl),
        .id_pc         (id_pc),
        .id_rs_val     (id_rs_val),
        .id_rt_val     (id_rt_val),
        .id_imm16      (id_imm16),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .flush         (flush),
        .cmux_sel      (cmux_sel),
        .pc_write_en   (pc_write_en),
        .ifid_write_en (ifid_write_en),
        .ex_valid      (ex_valid),
        .ex_ctrl       (ex_ctrl),
        .ex_pc         (ex_pc),
        .ex_rs_val     (ex_rs_val),
        .ex_rt_val     (ex_rt_val),
        .ex_imm16      (ex_imm16),
        .ex_dest       (ex_dest),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [23:0] c,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] pc, input logic [31:0] rsv, input logic [31:0] rtv,
                                 input logic [15:0] imm, input logic f);
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        id_pc = pc; id_rs_val = rsv; id_rt_val = rtv; id_imm16 = imm; flush = f;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        id_valid = 1'($urandom_range(0, 1)); id_ctrl = 24'($urandom);
        id_pc = $urandom; id_rs_val = $urandom; id_rt_val = $urandom;
        id_imm16 = 16'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
        id_rd = 5'($urandom); flush = 1'($urandom_range(0, 1));
        #3;
        vectors++;
        if ({ex_valid, ex_ctrl, ex_pc, ex_rs_val, ex_rt_val, ex_imm16, ex_dest} !== 142'd0) begin
            $display("[TB] FAIL reset_ex_regs got valid=%0b ctrl=%h dest=%0d pc=%h expected all zero",
                     ex_valid, ex_ctrl, ex_dest, ex_pc);
            miscompares++;
        end
        vectors++;
        if (stall_count !== 16'd0) begin
            $display("[TB] FAIL reset_stall_count got %h expected 0000", stall_count);
            miscompares++;
        end
        vectors++;
        if ({cmux_sel, pc_write_en, ifid_write_en} !== 3'b111) begin
            $display("[TB] FAIL reset_enables got %b expected 111", {cmux_sel, pc_write_en, ifid_write_en});
            miscompares++;
        end
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        expStall = 16'd0;
    endtask

    task automatic test_addiu();
        applyStimulus(1, 24'h040008, 2, 5, 7, 32'h100, 32'h10, 32'h20, 16'h0004, 0);
        #1;
        vectors++;
        if ({cmux_sel, pc_write_en, ifid_write_en} !== 3'b111) begin
            $display("[TB] FAIL addiu_enables got %b expected 111", {cmux_sel, pc_write_en, ifid_write_en});
            miscompares++;
        end
        tick();
        vectors++;
        if ({ex_valid, ex_dest, ex_rs_val} !== {1'b1, 5'd5, 32'h10}) begin
            $display("[TB] FAIL addiu_capture got valid=%0b dest=%0d rs_val=%h expected valid=1 dest=5 rs_val=00000010",
                     ex_valid, ex_dest, ex_rs_val);
            miscompares++;
        end
        vectors++;
        if ({ex_ctrl, ex_pc, ex_rt_val, ex_imm16} !== {24'h040008, 32'h100, 32'h20, 16'h0004}) begin
            $display("[TB] FAIL addiu_fields got ctrl=%h pc=%h rt_val=%h imm=%h expected 040008 00000100 00000020 0004",
                     ex_ctrl, ex_pc, ex_rt_val, ex_imm16);
            miscompares++;
        end
        applyStimulus(0, 24'h040008, 2, 5, 7, 32'h104, 32'h10, 32'h20, 16'h0004, 0);
        tick();
        vectors++;
        if ({ex_valid, ex_dest, ex_ctrl, ex_pc} !== 62'd0) begin
            $display("[TB] FAIL idle_bubble got valid=%0b dest=%0d ctrl=%h pc=%h expected all zero",
                     ex_valid, ex_dest, ex_ctrl, ex_pc);
            miscompares++;
        end
    endtask

    task automatic test_load_use();
        applyStimulus(1, 24'h04000B, 1, 8, 0, 32'h200, 32'h1000, 0, 16'h0010, 0);
        tick();
        vectors++;
        if ({ex_valid, ex_dest} !== {1'b1, 5'd8}) begin
            $display("[TB] FAIL lbu_capture got valid=%0b dest=%0d expected valid=1 dest=8", ex_valid, ex_dest);
            miscompares++;
        end
        applyStimulus(1, 24'h0C0008, 8, 9, 10, 32'h204, 32'hAA, 32'hBB, 16'h5020, 0);
        #1;
        vectors++;
        if ({cmux_sel, pc_write_en, ifid_write_en} !== 3'b000) begin
            $display("[TB] FAIL loaduse_rs_stall got %b expected 000", {cmux_sel, pc_write_en, ifid_write_en});
            miscompares++;
        end
        tick();
        expStall = expStall + 16'd1;
        vectors++;
        if ({ex_valid, ex_ctrl, ex_dest} !== 30'd0 || stall_count !== expStall) begin
            $display("[TB] FAIL loaduse_bubble got valid=%0b ctrl=%h dest=%0d count=%0d expected zeros count=%0d",
                     ex_valid, ex_ctrl, ex_dest, stall_count, expStall);
            miscompares++;
        end
        vectors++;
        if ({cmux_sel, pc_write_en, ifid_write_en} !== 3'b111) begin
            $display("[TB] FAIL loaduse_release got %b expected 111", {cmux_sel, pc_write_en, ifid_write_en});
            miscompares++;
        end
        tick();
        vectors++;
        if ({ex_valid, ex_dest, ex_rs_val, ex_pc} !== {1'b1, 5'd10, 32'hAA, 32'h204} || stall_count !== expStall) begin
            $display("[TB] FAIL subu_after_stall got valid=%0b dest=%0d rs_val=%h pc=%h count=%0d expected 1 10 000000aa 00000204 %0d",
                     ex_valid, ex_dest, ex_rs_val, ex_pc, stall_count, expStall);
            miscompares++;
        end
        applyStimulus(1, 24'h04000B, 1, 8, 0, 32'h208, 32'h1000, 0, 16'h0014, 0);
        tick();
        applyStimulus(1, 24'h0C0008, 3, 8, 11, 32'h20C, 32'h1, 32'h2, 16'h5820, 0);
        #1;
        vectors++;
        if ({cmux_sel, pc_write_en, ifid_write_en} !== 3'b000) begin
            $display("[TB] FAIL loaduse_rt_stall got %b expected 000", {cmux_sel, pc_write_en, ifid_write_en});
            miscompares++;
        end
        id_valid = 1'b0;
        #1;
        vectors++;
        if ({cmux_sel, pc_write_en, ifid_write_en} !== 3'b111) begin
            $display("[TB] FAIL invalid_id_no_stall got %b expected 111", {cmux_sel, pc_write_en, ifid_write_en});
            miscompares++;
        end
        tick();
        vectors++;
        if (ex_valid !== 1'b0 || stall_count !== expStall) begin
            $display("[TB] FAIL invalid_id_count got valid=%0b count=%0d expected valid=0 count=%0d",
                     ex_valid, stall_count, expStall);
            miscompares++;
        end
    endtask

    task automatic test_r0_and_dest();
        applyStimulus(1, 24'h04000B, 1, 0, 0, 32'h300, 32'h40, 0, 16'h0000, 0);
        tick();
        vectors++;
        if ({ex_valid, ex_dest, ex_ctrl} !== {1'b1, 5'd0, 24'h04000B}) begin
            $display("[TB] FAIL load_r0_capture got valid=%0b dest=%0d ctrl=%h expected 1 0 04000b",
                     ex_valid, ex_dest, ex_ctrl);
            miscompares++;
        end
        applyStimulus(1, 24'h0C0008, 0, 0, 12, 32'h304, 32'h5, 32'h6, 16'h6020, 0);
        #1;
        vectors++;
        if ({cmux_sel, pc_write_en, ifid_write_en} !== 3'b111) begin
            $display("[TB] FAIL r0_no_stall got %b expected 111", {cmux_sel, pc_write_en, ifid_write_en});
            miscompares++;
        end
        tick();
        vectors++;
        if ({ex_valid, ex_dest} !== {1'b1, 5'd12}) begin
            $display("[TB] FAIL rd_dest got valid=%0b dest=%0d expected valid=1 dest=12", ex_valid, ex_dest);
            miscompares++;
        end
        applyStimulus(1, 24'h080008, 4, 6, 13, 32'h308, 0, 0, 16'h0040, 0);
        tick();
        vectors++;
        if ({ex_valid, ex_dest, ex_pc} !== {1'b1, 5'd31, 32'h308}) begin
            $display("[TB] FAIL jal_dest got valid=%0b dest=%0d pc=%h expected 1 31 00000308", ex_valid, ex_dest, ex_pc);
            miscompares++;
        end
        applyStimulus(1, 24'h000004, 4, 7, 9, 32'h30C, 0, 0, 16'h0008, 0);
        tick();
        vectors++;
        if ({ex_valid, ex_dest} !== {1'b1, 5'd0}) begin
            $display("[TB] FAIL none_dest got valid=%0b dest=%0d expected valid=1 dest=0", ex_valid, ex_dest);
            miscompares++;
        end
    endtask

    task automatic test_flush_hazard();
        applyStimulus(1, 24'h04000B, 1, 8, 0, 32'h400, 32'h80, 0, 16'h0000, 0);
        tick();
        applyStimulus(1, 24'h0C0008, 8, 9, 10, 32'h404, 32'h1, 32'h2, 16'h5020, 1);
        #1;
        vectors++;
        if ({cmux_sel, pc_write_en, ifid_write_en} !== 3'b111) begin
            $display("[TB] FAIL flush_hazard_enables got %b expected 111", {cmux_sel, pc_write_en, ifid_write_en});
            miscompares++;
        end
        tick();
        vectors++;
        if ({ex_valid, ex_ctrl, ex_dest, ex_pc} !== 62'd0 || stall_count !== expStall) begin
            $display("[TB] FAIL flush_hazard_bubble got valid=%0b ctrl=%h dest=%0d count=%0d expected zeros count=%0d",
                     ex_valid, ex_ctrl, ex_dest, stall_count, expStall);
            miscompares++;
        end
        applyStimulus(1, 24'h040008, 2, 5, 7, 32'h408, 32'h3, 32'h4, 16'h0001, 1);
        tick();
        vectors++;
        if ({ex_valid, ex_dest, ex_rs_val} !== 38'd0) begin
            $display("[TB] FAIL flush_only_bubble got valid=%0b dest=%0d rs_val=%h expected zeros",
                     ex_valid, ex_dest, ex_rs_val);
            miscompares++;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_saturation();
        force dut.r_exValid = 1'b1;
        force dut.r_exCtrl  = 24'h000001;
        force dut.r_exDest  = 5'd8;
        applyStimulus(1, 24'h0C0008, 8, 9, 10, 32'h500, 32'h1, 32'h2, 16'h5020, 0);
        repeat (65540) tick();
        vectors++;
        if (stall_count !== 16'hFFFF) begin
            $display("[TB] FAIL stall_saturate got %h expected ffff", stall_count);
            miscompares++;
        end
        vectors++;
        if ({cmux_sel, pc_write_en, ifid_write_en} !== 3'b000) begin
            $display("[TB] FAIL saturate_still_stalling got %b expected 000", {cmux_sel, pc_write_en, ifid_write_en});
            miscompares++;
        end
        #2;
        release dut.r_exValid;
        release dut.r_exCtrl;
        release dut.r_exDest;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (stall_count !== 16'd0 || ex_valid !== 1'b0 || {cmux_sel, pc_write_en, ifid_write_en} !== 3'b111) begin
            $display("[TB] FAIL midstall_reset got count=%h valid=%0b enables=%b expected 0000 0 111",
                     stall_count, ex_valid, {cmux_sel, pc_write_en, ifid_write_en});
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        vectors++;
        if (stall_count !== 16'd0 || ex_valid !== 1'b0) begin
            $display("[TB] FAIL post_reset_idle got count=%h valid=%0b expected 0000 0", stall_count, ex_valid);
            miscompares++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        expStall = 16'd0;
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_addiu();
        test_load_use();
        test_r0_and_dest();
        test_flush_hazard();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection. It sits directly downstream of the control unit and its zeroing mux (`CMUX`). Each cycle it captures the 24-bit control word, decoded operands and the resolved destination register, and hands them to EX. It also generates the `CMUX` select and the PC / IF-ID write enables that insert a one-cycle bubble on a load-use dependency.

## Interface
- `DATA_W`, 32, operand/PC width
- `CTRL_W`, 24, control word width (bit map: [0] Load, [1] MemtoReg, [3] RegFileEnable, [19:18] WriteDestination, others pass through)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `id_valid` in 1: ID holds a real instruction
- `id_ctrl` in CTRL_W: control word after `CMUX` mux
- `id_pc` in DATA_W: PC of ID instruction
- `id_rs_val` / `id_rt_val` in DATA_W: register-file read data
- `id_imm16` in 16: instruction[15:0]
- `id_rs` / `id_rt` / `id_rd` in 5: instruction[25:21] / [20:16] / [15:11]
- `flush` in 1: squash ID instruction (taken branch/jump)
- `cmux_sel` out 1: 1 = pass control, 0 = force zeros
- `pc_write_en` / `ifid_write_en` out 1: 0 holds PC and IF/ID
- `ex_valid` out 1: EX holds a real instruction
- `ex_ctrl` out CTRL_W; `ex_pc`, `ex_rs_val`, `ex_rt_val` out DATA_W; `ex_imm16` out 16
- `ex_dest` out 5: resolved write register
- `stall_count` out 16: saturating count of inserted bubbles

## Operation
- Destination resolution in ID from `id_ctrl[19:18]`: 00 → 0, 01 → `id_rt`, 10 → 31, 11 → `id_rd`.
- Load-use hazard, evaluated combinationally: `hazard` = `ex_valid` & `ex_ctrl[0]` & (`ex_dest`≠0) & ((`ex_dest`==`id_rs` & `id_rs`≠0) | (`ex_dest`==`id_rt` & `id_rt`≠0)) & `id_valid`.
- Outputs while `hazard` & !`flush`:
  - `cmux_sel`=0, `pc_write_en`=0, `ifid_write_en`=0.
  - ID/EX loads a bubble.
  - `stall_count` increments, saturating at 16'hFFFF.
- Outside that condition: `cmux_sel`=1, `pc_write_en`=1, `ifid_write_en`=1.
- Bubble content: `ex_valid`=0 and every `ex_*` register is 0.
- Register update each edge, in priority order:
  1. `flush` → bubble.
  2. `hazard` → bubble.
  3. `id_valid`=0 → bubble.
  4. Otherwise capture all `id_*` fields, with `ex_valid`=1.
- A stall lasts exactly one cycle: the bubble clears `ex_valid`, so `hazard` deasserts on the next cycle. The held ID instruction is then captured.
- Flush during a hazard: flush wins, and enables stay 1 so the redirected fetch proceeds. `stall_count` does not increment.

## Timing
- Reset (async assert, sync-safe deassert):
  - All `ex_*` = 0, `ex_valid` = 0, `stall_count` = 0.
  - Therefore `cmux_sel`=1 and `pc_write_en`=`ifid_write_en`=1.
- Latency: ID inputs appear on `ex_*` one cycle after the capturing edge.
- `cmux_sel` and the write enables are combinational from current `ex_*` and `id_*`. They must settle within the same cycle; there is no register on them.
- `rst_n` asserted mid-stall: the pipeline empties immediately and enables return to 1 asynchronously.

## Structure
- The shared package holds:
  - Control-bit index constants (`CTRL_LOAD`=0, `CTRL_MEMTOREG`=1, `CTRL_REGWE`=3, `CTRL_WDST_LO`=18, `CTRL_WDST_HI`=19).
  - Destination encodings (`WDST_NONE`, `WDST_RT`, `WDST_R31`, `WDST_RD`).
  - The constant `REG_RA`=31.
- Sub-module `hazard_detect` is combinational. It takes `ex_valid`, `ex_ctrl[0]`, `ex_dest`, `id_valid`, `id_rs`, `id_rt`, `flush` and produces `hazard`, `cmux_sel`, `pc_write_en`, `ifid_write_en`.
- Top-level `id_ex_stage` holds the destination mux, the pipeline registers and `stall_count`.

## Test plan
- Reset with all inputs X-free random → all `ex_*`=0, `ex_valid`=0, `cmux_sel`=1, enables=1, `stall_count`=0.
- ADDIU capture (`id_ctrl[19:18]`=01, `id_rt`=5, `id_rs_val`=32'h10) → next cycle `ex_dest`=5, `ex_rs_val`=32'h10, `ex_valid`=1, no stall.
- LBU to r8 in EX (`ex_ctrl[0]`=1), SUBU in ID with `id_rs`=8 → `cmux_sel`=0 and enables=0 for exactly 1 cycle; SUBU reaches EX 2 cycles after LBU; `stall_count`=1.
- Load to r0 in EX, ID reads r0 → no stall; JAL capture (`id_ctrl[19:18]`=10) → `ex_dest`=31.
- Hazard and `flush` in the same cycle → bubble loaded, enables=1, `stall_count` unchanged.
- Force 65540 consecutive hazard cycles via bench-driven EX state → `stall_count` saturates at 16'hFFFF; `rst_n` pulse mid-stall → count 0, enables 1 immediately.
